// File: rtl/spi_command_decoder_if.sv
// Byte link from the SPI reader plus the register-file port of the command decoder.
interface spi_command_decoder_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic [7:0]        reply_byte;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic [7:0]        reg_rdata;
    logic              frame_err;

    modport slave (
        input  byte_in, byte_valid, reg_rdata,
        output reply_byte, reg_addr, reg_wdata, reg_we, frame_err
    );

    modport master (
        output byte_in, byte_valid, reg_rdata,
        input  reply_byte, reg_addr, reg_wdata, reg_we, frame_err
    );
endinterface

// File: rtl/spi_command_decoder.sv
// SPI byte-stream register protocol decoder: write strobe 1 cycle after a data byte, read reply 2 cycles after the byte.
// No backpressure: bytes must arrive at least 2 cycles apart; frames end by inactivity timeout.
module spi_command_decoder #(
    parameter int         ADDR_W     = 7,
    parameter int         TIMEOUT    = 1000,
    parameter logic [7:0] IDLE_REPLY = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_command_decoder_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE_DATA,
        READ_FETCH,
        READ_STREAM
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic             got_data;
    logic             timeout;

    // An arriving byte always beats the timeout in the same cycle.
    assign timeout = (state != IDLE) && !bus.byte_valid && (idle_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.byte_valid) state_nxt = bus.byte_in[7] ? WRITE_DATA : READ_FETCH;
            end
            WRITE_DATA: begin
                if (timeout) state_nxt = IDLE;
            end
            READ_FETCH: begin
                state_nxt = timeout ? IDLE : READ_STREAM;
            end
            READ_STREAM: begin
                if (bus.byte_valid) state_nxt = READ_FETCH;
                else if (timeout)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.reply_byte <= IDLE_REPLY;
            bus.reg_addr   <= '0;
            bus.reg_wdata  <= '0;
            bus.reg_we     <= 1'b0;
            bus.frame_err  <= 1'b0;
            idle_cnt       <= '0;
            got_data       <= 1'b0;
        end else begin
            bus.reg_we    <= 1'b0;
            bus.frame_err <= 1'b0;

            if (state == IDLE || bus.byte_valid)
                idle_cnt <= '0;
            else if (idle_cnt != CNT_W'(TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;

            // Burst auto-increment lands the cycle after the strobe.
            if (bus.reg_we)
                bus.reg_addr <= bus.reg_addr + 1'b1;

            case (state)
                IDLE: begin
                    if (bus.byte_valid) begin
                        bus.reg_addr <= bus.byte_in[ADDR_W-1:0];
                        got_data     <= 1'b0;
                    end
                end
                WRITE_DATA: begin
                    if (bus.byte_valid) begin
                        bus.reg_wdata <= bus.byte_in;
                        bus.reg_we    <= 1'b1;
                        got_data      <= 1'b1;
                    end else if (timeout) begin
                        bus.reply_byte <= IDLE_REPLY;
                        bus.frame_err  <= !got_data;
                    end
                end
                READ_FETCH: begin
                    bus.reply_byte <= timeout ? IDLE_REPLY : bus.reg_rdata;
                end
                READ_STREAM: begin
                    if (bus.byte_valid)
                        bus.reg_addr <= bus.reg_addr + 1'b1;
                    else if (timeout)
                        bus.reply_byte <= IDLE_REPLY;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/spi_command_decoder.md
# spi_command_decoder

Byte-level command decoder sitting directly downstream of the SPI slave byte reader. Consumes each received byte (data + one-cycle valid pulse), parses a read/write register protocol with address auto-increment, drives a simple register-file port, and returns the byte the reader shifts out on its next transfer. Frames are delimited by an inactivity timeout because the link carries no chip select.

## Interface
- ADDR_W, 7: register address width; addresses wrap modulo 2^ADDR_W.
- TIMEOUT, 1000: clk cycles without a received byte after which a frame is abandoned.
- IDLE_REPLY, 8'hA5: reply_byte value whenever no read data is pending.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  last byte received from the SPI reader.
- byte_valid  in  1  one-cycle pulse, byte_in valid in that cycle.
- reply_byte  out  8  byte for the reader to transmit on the next transfer.
- reg_addr  out  ADDR_W  register-file address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_rdata  in  8  register read data, combinational from reg_addr (valid same cycle).
- frame_err  out  1  one-cycle pulse when a frame is abandoned by timeout mid-write.

## Operation
- Command byte: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = start address (bits above ADDR_W, excluding bit7, ignored).
- States: IDLE, WRITE_DATA, READ_FETCH, READ_STREAM.
- IDLE + byte_valid: reg_addr <= byte_in[ADDR_W-1:0]; bit7=1 -> WRITE_DATA; bit7=0 -> READ_FETCH.
- WRITE_DATA + byte_valid: reg_wdata <= byte_in, reg_we = 1 next cycle for exactly one cycle at current reg_addr; reg_addr increments in the cycle after the strobe; stays in WRITE_DATA (burst).
- READ_FETCH (no byte needed): reply_byte <= reg_rdata; -> READ_STREAM.
- READ_STREAM + byte_valid (byte_in ignored): reg_addr <= reg_addr + 1; -> READ_FETCH.
- Address arithmetic is ADDR_W bits; 2^ADDR_W-1 + 1 wraps to 0.
- Inactivity counter: cleared on every byte_valid and in IDLE, else increments (saturating). On reaching TIMEOUT in any non-IDLE state: -> IDLE, reply_byte <= IDLE_REPLY. frame_err pulses only if leaving WRITE_DATA with no data byte received since the command byte.
- byte_valid in the same cycle the counter reaches TIMEOUT: byte wins, processed in current state, counter cleared.
- reg_we never asserts outside WRITE_DATA; byte_valid while reg_we high is legal (back-to-back bytes at 1-cycle spacing need not be supported; minimum spacing 2 cycles).

## Timing
- Reset values: state IDLE, reply_byte = IDLE_REPLY, reg_addr = 0, reg_wdata = 0, reg_we = 0, frame_err = 0, counter = 0.
- Write latency: byte_valid at edge N -> reg_we high in cycle N+1 with reg_wdata/reg_addr stable; reg_addr+1 visible at N+2.
- Read latency: command byte at edge N -> reg_addr at N+1 -> reply_byte = reg_rdata at N+2, held until the next byte_valid+2 cycles.
- reply_byte changes only on READ_FETCH or timeout/reset; stable otherwise.
- Reset asserted mid-frame: immediate return to reset values, pending reg_we cleared asynchronously.

## Test plan
- Reset: rst high 2 cycles -> reply_byte = 8'hA5, reg_we = 0, reg_addr = 0.
- Write burst: bytes 8'h85, 8'h11, 8'h22 -> reg_we pulses twice, (addr 5, 8'h11), (addr 6, 8'h22), each one cycle wide.
- Read stream: preload regs 3/4 = 8'h3C/8'hC3; bytes 8'h03, 8'h00 -> reply_byte = 8'h3C two cycles after first byte, 8'hC3 two cycles after second.
- Wrap: write command 8'hFF then two data bytes -> writes land at addr 127 then 0.
- Timeout: byte 8'h90 then silence TIMEOUT cycles -> frame_err one pulse, state IDLE; next byte 8'h02 decoded as command (read addr 2), not data.
- Timeout race: byte_valid arriving exactly at counter = TIMEOUT in WRITE_DATA -> treated as data (reg_we pulses), no frame_err.
